// File: rtl/gate_if.sv
// Purpose : bundles the operand, config and result signals of the gate block.
// Ports   : P/Q/R operands, cfg_we/cfg_data table write; F, f_rise, tt, f_count results.
// master drives operands and config and reads results; slave is the gate side.
interface gate_if #(
    parameter int CNT_W = 16
);
    logic             P;
    logic             Q;
    logic             R;
    logic             cfg_we;
    logic [7:0]       cfg_data;
    logic             F;
    logic             f_rise;
    logic [7:0]       tt;
    logic [CNT_W-1:0] f_count;

    modport master (
        output P, Q, R, cfg_we, cfg_data,
        input  F, f_rise, tt, f_count
    );

    modport slave (
        input  P, Q, R, cfg_we, cfg_data,
        output F, f_rise, tt, f_count
    );
endinterface

// File: rtl/gate.sv
// Purpose : programmable 3-input function; F = tt[{P,Q,R}], with a rise pulse and a ones counter.
// Latency : 1 cycle from P/Q/R to F; a table write takes effect from the following edge.
// Backpr. : none, a new lookup is accepted every cycle.
// Ports   : clk, rst (sync, active-high), bus (gate_if.slave: P,Q,R,cfg_we,cfg_data -> F,f_rise,tt,f_count).
module gate #(
    parameter logic [7:0] RESET_TT = 8'hE8,
    parameter int         CNT_W    = 16
) (
    input  logic   clk,
    input  logic   rst,
    gate_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [7:0]       tt_q;
    logic             f_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q;

    logic [2:0] idx;
    logic       f_next;

    // Lookup uses the table currently held, so a write on the same edge
    // only affects lookups from the next edge onward.
    assign idx    = {bus.P, bus.Q, bus.R};
    assign f_next = tt_q[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            tt_q   <= RESET_TT;
            f_q    <= 1'b0;
            rise_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            f_q    <= f_next;
            rise_q <= f_next & ~f_q;
            // Counter saturates at all-ones rather than wrapping.
            if (f_next && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (bus.cfg_we) begin
                tt_q <= bus.cfg_data;
            end
        end
    end

    assign bus.F       = f_q;
    assign bus.f_rise  = rise_q;
    assign bus.tt      = tt_q;
    assign bus.f_count = cnt_q;
endmodule

// File: tb/tb_gate.sv
module tb_gate;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic p = 1'b0, q = 1'b0, r = 1'b0;
    logic we = 1'b0;
    logic [7:0] data = 8'h00;

    always #5 clk = ~clk;

    gate_if #(.CNT_W(16)) bus16 ();
    gate_if #(.CNT_W(4))  bus4 ();

    assign bus16.P = p;  assign bus16.Q = q;  assign bus16.R = r;
    assign bus16.cfg_we = we;  assign bus16.cfg_data = data;
    assign bus4.P = p;   assign bus4.Q = q;   assign bus4.R = r;
    assign bus4.cfg_we = we;   assign bus4.cfg_data = data;

    gate #(.RESET_TT(8'hE8), .CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(bus16));
    gate #(.RESET_TT(8'hE8), .CNT_W(4))  dut_s (.clk(clk), .rst(rst), .bus(bus4));

    int errors = 0;
    int checks = 0;

    // Behavioural reference: state of the block as seen after each edge.
    logic [7:0] m_tt = 8'hE8;
    logic       m_f = 1'b0;
    logic       m_rise = 1'b0;
    int         m_cnt16 = 0;
    int         m_cnt4 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic rst_i, input logic we_i, input logic [7:0] d_i, input logic [2:0] pqr);
        rst = rst_i; we = we_i; data = d_i;
        {p, q, r} = pqr;
    endtask

    // Advance the model from the inputs present at the edge, clock once, compare.
    task automatic step();
        logic nf;
        if (rst) begin
            m_tt = 8'hE8; m_f = 1'b0; m_rise = 1'b0; m_cnt16 = 0; m_cnt4 = 0;
        end else begin
            nf = m_tt[{p, q, r}];
            m_rise = nf && !m_f;
            m_f = nf;
            if (nf) begin
                m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
                m_cnt4  = (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
            end
            if (we) m_tt = data;
        end
        @(posedge clk);
        #1;
        chk("model_F",      32'(bus16.F),       32'(m_f));
        chk("model_rise",   32'(bus16.f_rise),  32'(m_rise));
        chk("model_tt",     32'(bus16.tt),      32'(m_tt));
        chk("model_cnt16",  32'(bus16.f_count), 32'(m_cnt16));
        chk("model_cnt4",   32'(bus4.f_count),  32'(m_cnt4));
        chk("model_F4",     32'(bus4.F),        32'(m_f));
    endtask

    typedef struct {
        logic       rst;
        logic       we;
        logic [7:0] data;
        logic [2:0] pqr;
        logic       exp_f;
        logic       exp_rise;
        logic [7:0] exp_tt;
    } vec_t;

    vec_t vecs[18];

    initial begin
        int c0;
        // Reset, default-table sweep, then XOR3 table load and sweep.
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 8'hE8};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 8'hE8};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 3'b001, 1'b0, 1'b0, 8'hE8};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 3'b010, 1'b0, 1'b0, 8'hE8};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 3'b011, 1'b1, 1'b1, 8'hE8};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 3'b100, 1'b0, 1'b0, 8'hE8};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 3'b101, 1'b1, 1'b1, 8'hE8};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 3'b110, 1'b1, 1'b0, 8'hE8};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 3'b111, 1'b1, 1'b0, 8'hE8};
        vecs[9]  = '{1'b0, 1'b1, 8'h96, 3'b000, 1'b0, 1'b0, 8'h96};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 8'h96};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 3'b001, 1'b1, 1'b1, 8'h96};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 3'b010, 1'b1, 1'b0, 8'h96};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 3'b011, 1'b0, 1'b0, 8'h96};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 3'b100, 1'b1, 1'b1, 8'h96};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 3'b101, 1'b0, 1'b0, 8'h96};
        vecs[16] = '{1'b0, 1'b0, 8'h00, 3'b110, 1'b0, 1'b0, 8'h96};
        vecs[17] = '{1'b0, 1'b0, 8'h00, 3'b111, 1'b1, 1'b1, 8'h96};

        #2;
        for (int i = 0; i < 18; i++) begin
            set_in(vecs[i].rst, vecs[i].we, vecs[i].data, vecs[i].pqr);
            step();
            chk($sformatf("vec%0d_F", i),    32'(bus16.F),      32'(vecs[i].exp_f));
            chk($sformatf("vec%0d_rise", i), 32'(bus16.f_rise), 32'(vecs[i].exp_rise));
            chk($sformatf("vec%0d_tt", i),   32'(bus16.tt),     32'(vecs[i].exp_tt));
        end
        // Default sweep gives 4 ones, XOR3 sweep gives 4 more.
        chk("sweep_count", 32'(bus16.f_count), 32'd8);

        // Same-edge write: lookup uses the old table.
        set_in(1'b1, 1'b0, 8'h00, 3'b011); step();
        set_in(1'b0, 1'b0, 8'h00, 3'b011); step();
        chk("sameedge_pre_F", 32'(bus16.F), 32'd1);
        set_in(1'b0, 1'b1, 8'h00, 3'b011); step();
        chk("sameedge_F", 32'(bus16.F), 32'd1);
        chk("sameedge_tt", 32'(bus16.tt), 32'h00);
        set_in(1'b0, 1'b0, 8'h00, 3'b011); step();
        chk("sameedge_next_F", 32'(bus16.F), 32'd0);

        // Reset mid-run overrides a pending write and clears everything.
        set_in(1'b1, 1'b0, 8'h00, 3'b000); step();
        set_in(1'b0, 1'b1, 8'h96, 3'b000); step();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'b0, 8'h00, 3'b111); step();
        end
        chk("midrst_pre_cnt", 32'(bus16.f_count), 32'd5);
        chk("midrst_pre_F", 32'(bus16.F), 32'd1);
        chk("midrst_pre_tt", 32'(bus16.tt), 32'h96);
        set_in(1'b1, 1'b1, 8'h3C, 3'b111); step();
        chk("midrst_F", 32'(bus16.F), 32'd0);
        chk("midrst_cnt", 32'(bus16.f_count), 32'd0);
        chk("midrst_tt", 32'(bus16.tt), 32'hE8);
        chk("midrst_rise", 32'(bus16.f_rise), 32'd0);
        set_in(1'b0, 1'b0, 8'h00, 3'b011); step();
        chk("first_lookup_F", 32'(bus16.F), 32'd1);

        // Rise pulse: 000 then 111 held 4 cycles.
        set_in(1'b0, 1'b0, 8'h00, 3'b000); step();
        c0 = int'(bus16.f_count);
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b0, 8'h00, 3'b111); step();
            chk($sformatf("rise_pulse%0d", i), 32'(bus16.f_rise), (i == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rise_F%0d", i), 32'(bus16.F), 32'd1);
        end
        chk("rise_cnt_delta", 32'(int'(bus16.f_count) - c0), 32'd4);

        // Saturation of the 4-bit counter.
        set_in(1'b1, 1'b0, 8'h00, 3'b111); step();
        for (int i = 0; i < 20; i++) begin
            set_in(1'b0, 1'b0, 8'h00, 3'b111); step();
        end
        chk("sat_cnt4", 32'(bus4.f_count), 32'd15);
        chk("sat_cnt16", 32'(bus16.f_count), 32'd20);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                   ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
                   8'($urandom), 3'($urandom));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gate.md
GATE -- requirements
Module: gate

Interface
REQ-001 Parameter RESET_TT, default 8'hE8, SHALL be the truth table loaded at reset, indexed by {P,Q,R}; E8 is the 3-input majority function.
REQ-002 Parameter CNT_W, default 16, SHALL be the width of the ones counter.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 P  input  1  SHALL be the function operand and the MSB of the table index.
REQ-007 Q  input  1  SHALL be the function operand and the middle bit of the table index.
REQ-008 R  input  1  SHALL be the function operand and the LSB of the table index.
REQ-009 cfg_we  input  1  SHALL be the truth-table write strobe.
REQ-010 cfg_data  input  8  SHALL be the new truth table; bit i is the output for index i.
REQ-011 F  output  1  SHALL be the registered function output.
REQ-012 f_rise  output  1  SHALL be a registered one-cycle pulse asserted when F goes from 0 to 1.
REQ-013 tt  output  8  SHALL be a readback of the active truth table.
REQ-014 f_count  output  CNT_W  SHALL be a saturating count of clock cycles in which F is loaded with 1.

Function
REQ-015 Each rising edge without rst SHALL load F with tt[{P,Q,R}] sampled at that edge; latency is exactly 1 cycle.
REQ-016 There SHALL be no combinational path from P, Q, R, cfg_we or cfg_data to any output.
REQ-017 When cfg_we=1, tt SHALL load cfg_data at the edge.
REQ-018 A lookup at the same edge as a write SHALL use the old tt; the new table applies from the next edge.
REQ-019 f_rise SHALL be 1 in the cycle after an edge where F changed from 0 to 1, and 0 otherwise.
REQ-020 f_count SHALL increment by 1 at each edge where F is loaded with 1.
REQ-021 f_count SHALL hold at all-ones (2^CNT_W-1) without wrapping.
REQ-022 Inputs held constant for many cycles SHALL keep F constant.
REQ-023 Inputs held constant SHALL NOT cause f_rise to repeat, but f_count SHALL keep counting while F stays 1.
REQ-024 X on P, Q or R is outside the design's responsibility; there is no input checking.

Reset
REQ-025 While rst=1 at an edge: F=0, f_rise=0, f_count=0 and tt=RESET_TT.
REQ-026 Reset SHALL override cfg_we in the same cycle.
REQ-027 The first lookup after reset SHALL occur at the first edge with rst=0, using RESET_TT.
REQ-028 A reset mid-operation SHALL discard any user-loaded table and counter value within that single edge.

Verification
REQ-029 Sweep, default table: after reset, drive {P,Q,R} = 000,001,010,011,100,101,110,111, each held 25 time units with a 10-unit clock. Required: F = 0,0,0,1,0,1,1,1, each one cycle after the input changes; f_count increases only while F=1.
REQ-030 Table load: set cfg_data=8'h96 with cfg_we for 1 cycle, then sweep. Required: tt=8'h96 and F follows XOR3 = 0,1,1,0,1,0,0,1.
REQ-031 Same-edge write: hold PQR=011 with table E8 and write 8'h00. Required: F=1 after that edge and F=0 after the following edge.
REQ-032 Reset mid-run: assert rst for 1 cycle with tt=8'h96, F=1, f_count=5 and cfg_we=1. Required: F=0, f_count=0, tt=8'hE8 and f_rise=0.
REQ-033 Rise pulse: change PQR from 000 to 111 and hold for 4 cycles. Required: f_rise is high for exactly 1 cycle, aligned with F's first 1 cycle; f_count increases by 4.
REQ-034 Saturation: with CNT_W=4, hold PQR=111 for 20 cycles. Required: f_count stops at 15 and does not wrap to 0.
